dmem_responder: RTL and testbench

- Data-memory responder on the far end of the MEM-stage load/store interface of the 5-stage pipeline CPU.
- Accepts one request at a time from the MEM stage and applies a programmable access latency.
- Completes word/byte-enabled writes and registered reads.
- Drives a stall that freezes the pipeline until the response cycle.

---
 rtl/dmem_responder.sv | 165 ++++++++++++++++
 tb/tb_dmem_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the MEM stage, registered reads, byte-enabled writes.
// Latency: o_rvalid exactly LATENCY cycles after the accept cycle; earliest next accept is the cycle after the response.
// Backpressure: o_ready only in IDLE; o_stall freezes the pipeline from the accept cycle through the last WAIT cycle.
// Optional: define DMEM_ERR_EN to flag misaligned accesses (no memory access, o_err=1, o_rdata=0).
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_be,
    output logic        o_ready,
    output logic        o_stall,
    output logic        o_rvalid,
    output logic [31:0] o_rdata,
    output logic        o_err
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam int         DEPTH   = 1 << ADDR_W;
    localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       mem [DEPTH];

    logic              accept;
    logic              go_resp;
    logic              mis;
    logic              eff_we;
    logic [ADDR_W+1:0] eff_addr;
    logic [31:0]       eff_wdata;
    logic [3:0]        eff_be;
    logic [ADDR_W-1:0] idx;
    logic [3:0]        mem_be;
    logic              unused_ok;

    assign accept = (state_q == ST_IDLE) && i_req;

    // The response edge follows the accept edge directly when LATENCY is 1,
    // so the commit path must see the live inputs in IDLE and the latched copy otherwise.
    assign go_resp   = (accept && (LATENCY == 1)) || ((state_q == ST_WAIT) && (cnt_q == 4'd1));
    assign eff_we    = (state_q == ST_IDLE) ? i_we                  : we_q;
    assign eff_addr  = (state_q == ST_IDLE) ? i_addr[ADDR_W+1:0]    : addr_q;
    assign eff_wdata = (state_q == ST_IDLE) ? i_wdata               : wdata_q;
    assign eff_be    = (state_q == ST_IDLE) ? i_be                  : be_q;
    assign idx       = eff_addr[ADDR_W+1:2];

`ifdef DMEM_ERR_EN
    assign mis = (eff_addr[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    // Upper address bits wrap by design; low bits only matter with misalignment checking.
    assign unused_ok = ^{i_addr[31:ADDR_W+2], eff_addr[1:0]};

    // Next-state, latency counter and request latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d    = i_we;
                    addr_d  = i_addr[ADDR_W+1:0];
                    wdata_d = i_wdata;
                    be_d    = i_be;
                    cnt_d   = LAT_M1;
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Response data: loads capture the word, stores and misaligned accesses return zero.
    always_comb begin
        rdata_d = rdata_q;
        if (go_resp) begin
            rdata_d = (eff_we || mis) ? 32'd0 : mem[idx];
        end
    end

    // Commit a store on the edge entering RESP; a reset on that edge discards it.
    assign mem_be = (go_resp && eff_we && !mis && i_rst_n) ? eff_be : 4'b0000;

    // Control and response registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory array: byte-granular writes, contents survive reset.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) begin
                mem[idx][8*b +: 8] <= eff_wdata[8*b +: 8];
            end
        end
    end

`ifdef DMEM_ERR_EN
    logic err_q, err_d;

    assign err_d = go_resp && mis;

    // Error flag registered alongside the response pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    assign o_ready  = (state_q == ST_IDLE);
    assign o_stall  = accept || (state_q == ST_WAIT);
    assign o_rvalid = (state_q == ST_RESP);
    assign o_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed scenarios plus randomized traffic against a word-array reference model.
// A second instance with LATENCY=1 exercises back-to-back accesses with the request held high.
module tb_dmem_responder;
    localparam int LAT  = 2;
    localparam int WRDS = 256;
`ifdef DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, i_we;
    logic [31:0] i_addr, i_wdata;
    logic [3:0]  i_be;
    logic        o_ready, o_stall, o_rvalid, o_err;
    logic [31:0] o_rdata;

    logic        b_req, b_we;
    logic [31:0] b_addr, b_wdata;
    logic [3:0]  b_be;
    logic        b_ready, b_stall, b_rvalid, b_err;
    logic [31:0] b_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ref_mem [WRDS];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(8), .LATENCY(LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_be(i_be), .o_ready(o_ready), .o_stall(o_stall),
        .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_err(o_err)
    );

    dmem_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(b_req), .i_we(b_we), .i_addr(b_addr),
        .i_wdata(b_wdata), .i_be(b_be), .o_ready(b_ready), .o_stall(b_stall),
        .o_rvalid(b_rvalid), .o_rdata(b_rdata), .o_err(b_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One access on the main DUT, starting and ending on a falling edge with the DUT idle.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rd, output logic er);
        int cyc;
        i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata; i_be = be;
        #1;
        check("ready_accept", 32'(o_ready), 32'd1);
        check("stall_accept", 32'(o_stall), 32'd1);
        @(posedge clk);
        #1;
        // Inputs after accept must not matter; i_req may even drop.
        i_we = 1'($urandom); i_addr = $urandom; i_wdata = $urandom; i_be = 4'($urandom);
        i_req = 1'($urandom_range(0, 1));
        @(negedge clk);
        cyc = 1;
        while (!o_rvalid && cyc < 40) begin
            check("stall_wait", 32'(o_stall), 32'd1);
            check("ready_wait", 32'(o_ready), 32'd0);
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(LAT));
        check("ready_resp", 32'(o_ready), 32'd0);
        check("stall_resp", 32'(o_stall), 32'd0);
        rd = o_rdata;
        er = o_err;
        i_req = 1'b0;
        @(negedge clk);
        check("rvalid_pulse", 32'(o_rvalid), 32'd0);
    endtask

    // Access plus comparison against the reference model, which is then updated.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input string tag);
        logic [31:0] rd, exp_rd;
        logic        er, exp_er;
        int          w;
        w      = int'((addr >> 2) % WRDS);
        exp_er = ERR_EN && (addr[1:0] != 2'b00);
        exp_rd = 32'd0;
        if (!we && !exp_er) exp_rd = ref_mem[w];
        access(we, addr, wdata, be, rd, er);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, 32'(er), 32'(exp_er));
        if (we && !exp_er) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ref_mem[w][8*b +: 8] = wdata[8*b +: 8];
            end
        end
    endtask

    initial begin
        logic [31:0] pa, pd;
        rst_n = 1'b0;
        i_req = 1'b0; i_we = 1'b0; i_addr = 32'd0; i_wdata = 32'd0; i_be = 4'd0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 32'd0; b_wdata = 32'd0; b_be = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_stall", 32'(o_stall), 32'd0);
        check("rst_rvalid", 32'(o_rvalid), 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Store then load back.
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "st10");
        txn(1'b0, 32'h10, 32'h0, 4'h0, "ld10");
        check("ld10_const", ref_mem[4], 32'hDEADBEEF);

        // Byte-enable merge.
        txn(1'b1, 32'h20, 32'h11223344, 4'hF, "st20");
        txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "st20be");
        txn(1'b0, 32'h20, 32'h0, 4'h0, "ld20");
        check("merge_const", ref_mem[8], 32'h11BB33DD);

        // Zero byte enables leave the word alone.
        txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, "st20be0");
        txn(1'b0, 32'h20, 32'h0, 4'h0, "ld20b");

        // Address wrap.
        txn(1'b1, 32'h400, 32'h5A5A1234, 4'hF, "st400");
        txn(1'b0, 32'h000, 32'h0, 4'h0, "ld000");

        // Misaligned load.
        txn(1'b0, 32'h13, 32'h0, 4'h0, "ld13");

        // Reset during WAIT of a store must discard it.
        txn(1'b1, 32'h30, 32'h0, 4'hF, "st30z");
        i_req = 1'b1; i_we = 1'b1; i_addr = 32'h30; i_wdata = 32'hCAFEF00D; i_be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        check("midrst_stall", 32'(o_stall), 32'd1);
        rst_n = 1'b0;
        i_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrst_rvalid", 32'(o_rvalid), 32'd0);
            check("midrst_ready", 32'(o_ready), 32'd1);
        end
        check("midrst_rdata", o_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle_rvalid", 32'(o_rvalid), 32'd0);
        txn(1'b0, 32'h30, 32'h0, 4'h0, "ld30");

        // Fill every word so random loads have known contents.
        for (int i = 0; i < WRDS; i++) begin
            txn(1'b1, 32'(i * 4), $urandom, 4'hF, "fill");
        end

        // Random traffic, including misaligned and out-of-range addresses.
        for (int i = 0; i < 150; i++) begin
            txn(1'($urandom), $urandom, $urandom, 4'($urandom), "rnd");
        end

        // LATENCY=1 instance with the request held: alternating store/load pairs.
        pa = 32'd0; pd = 32'd0;
        for (int k = 0; k < 24; k++) begin
            int t;
            t = k / 2;
            if (k % 2 == 0) begin
                b_req = 1'b1;
                b_be  = 4'hF;
                if (t % 2 == 0) begin
                    pa = {22'd0, 8'($urandom), 2'b00};
                    pd = $urandom;
                    b_we = 1'b1; b_addr = pa; b_wdata = pd;
                end else begin
                    b_we = 1'b0; b_addr = pa; b_wdata = $urandom;
                end
                #1;
                check("b2b_idle_rvalid", 32'(b_rvalid), 32'd0);
                check("b2b_idle_ready", 32'(b_ready), 32'd1);
                check("b2b_idle_stall", 32'(b_stall), 32'd1);
            end else begin
                #1;
                check("b2b_resp_rvalid", 32'(b_rvalid), 32'd1);
                check("b2b_resp_ready", 32'(b_ready), 32'd0);
                check("b2b_resp_stall", 32'(b_stall), 32'd0);
                check("b2b_rdata", b_rdata, (t % 2 == 0) ? 32'd0 : pd);
                check("b2b_err", 32'(b_err), 32'd0);
            end
            @(negedge clk);
        end
        b_req = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
